// File: rtl/mips_alu.sv
// ----------------------------------------------------------------------------
// mips_alu
//
// 32-bit integer ALU for the modified MIPS datapath. The primary/secondary
// results and the zero/overflow flags are purely combinational. A HI/LO
// register pair captures multiply/divide results on the rising clock edge
// for later mfhi/mflo reads.
//
// Ports
//   clk      in   1   system clock; HI/LO update on rising edge
//   rst      in   1   asynchronous, active-high reset; clears HI/LO
//   in1      in  32   operand A
//   in2      in  32   operand B
//   control  in   4   operation select
//   out1     out 32   primary result (low word / quotient for mul/div)
//   out2     out 32   secondary result (high word / remainder), else 0
//   o        out  1   overflow / carry / borrow flag
//   z        out  1   1 when out1 == 0
//   hi       out 32   HI register
//   lo       out 32   LO register
// ----------------------------------------------------------------------------
module mips_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  control,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic        o,
    output logic        z,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADDU = 4'b0010,
        OP_SUBU = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_NOR  = 4'b0111,
        OP_ADD  = 4'b1010,
        OP_SUB  = 4'b1011,
        OP_MULU = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_MUL  = 4'b1110,
        OP_DIV  = 4'b1111
    } alu_op_e;

    // Shared arithmetic, computed once and selected by the case below.
    logic [32:0] sum_c;      // in1 + in2 with carry out
    logic [31:0] diff;       // in2 - in1
    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot_m;
    logic [31:0] rem_m;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic        div_by_zero;
    logic        div_ovf;

    assign sum_c  = {1'b0, in1} + {1'b0, in2};
    assign diff   = in2 - in1;
    assign prod_u = {32'd0, in1} * {32'd0, in2};
    // The low 64 bits of the product of sign-extended operands equal the
    // signed 64-bit product, so an unsigned multiplier suffices.
    assign prod_s = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};

    assign quot_u = in1 / in2;
    assign rem_u  = in1 % in2;

    // Signed divide on magnitudes: avoids the native signed-divide trap for
    // 0x80000000 / -1, which falls out here as quotient 0x80000000, rem 0.
    // Quotient is negative when signs differ; remainder follows the dividend.
    assign mag_a  = in1[31] ? (32'd0 - in1) : in1;
    assign mag_b  = in2[31] ? (32'd0 - in2) : in2;
    assign quot_m = mag_a / mag_b;
    assign rem_m  = mag_a % mag_b;
    assign quot_s = (in1[31] ^ in2[31]) ? (32'd0 - quot_m) : quot_m;
    assign rem_s  = in1[31] ? (32'd0 - rem_m) : rem_m;

    assign div_by_zero = (in2 == 32'd0);
    assign div_ovf     = (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned and infers a latch.
        out1 = 32'd0;
        out2 = 32'd0;
        o    = 1'b0;
        case (control)
            OP_AND:  out1 = in1 & in2;
            OP_OR:   out1 = in1 | in2;
            OP_ADDU: begin
                out1 = sum_c[31:0];
                o    = sum_c[32];
            end
            OP_SUBU: begin
                out1 = diff;
                o    = (in1 > in2);
            end
            OP_SLT:  out1 = {31'd0, $signed(in1) < $signed(in2)};
            OP_SLTU: out1 = {31'd0, in1 < in2};
            OP_NOR:  out1 = ~(in1 | in2);
            OP_ADD: begin
                out1 = sum_c[31:0];
                o    = (in1[31] == in2[31]) && (sum_c[31] != in1[31]);
            end
            OP_SUB: begin
                // in2 - in1 overflows when the operands differ in sign and
                // the result sign differs from the minuend (in2).
                out1 = diff;
                o    = (in2[31] != in1[31]) && (diff[31] != in2[31]);
            end
            OP_MULU: {out2, out1} = prod_u;
            OP_MUL:  {out2, out1} = prod_s;
            OP_DIVU: begin
                if (div_by_zero) begin
                    out1 = 32'hFFFF_FFFF;
                    out2 = in1;
                    o    = 1'b1;
                end else begin
                    out1 = quot_u;
                    out2 = rem_u;
                end
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    out1 = 32'hFFFF_FFFF;
                    out2 = in1;
                    o    = 1'b1;
                end else begin
                    out1 = quot_s;
                    out2 = rem_s;
                    o    = div_ovf;
                end
            end
            default: ;  // unused encodings keep the all-zero defaults
        endcase
    end

    assign z = (out1 == 32'd0);

    // Encodings 11xx are the multiply/divide group.
    logic is_muldiv;
    assign is_muldiv = (control[3:2] == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: HI/LO are architectural state read by mfhi/mflo, so they are
        // reset explicitly rather than left to power-up values.
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (is_muldiv) begin
            // NOTE: non-blocking assignments keep register updates ordered
            // correctly against every other process sampling this edge.
            hi <= out2;
            lo <= out1;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  control;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        o;
    logic        z;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_alu dut (
        .clk     (clk),
        .rst     (rst),
        .in1     (in1),
        .in2     (in2),
        .control (control),
        .out1    (out1),
        .out2    (out2),
        .o       (o),
        .z       (z),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eo;
        logic        ez;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] c,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eo, input logic ez);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.ctrl = c;
        v.e1 = e1; v.e2 = e2; v.eo = eo; v.ez = ez;
        vecs.push_back(v);
    endfunction

    // Drive one vector, push its expectation, compare the combinational
    // outputs, then check HI/LO against the bench model after the edge.
    task automatic apply_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        in1 = v.a; in2 = v.b; control = v.ctrl;
        exp_q.push_back(v);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = exp_q.pop_front();
            check({e.name, ".out1"}, out1, e.e1);
            check({e.name, ".out2"}, out2, e.e2);
            check({e.name, ".o"}, {31'd0, o}, {31'd0, e.eo});
            check({e.name, ".z"}, {31'd0, z}, {31'd0, e.ez});
        end
        @(posedge clk);
        #1;
        if (v.ctrl[3:2] == 2'b11) begin
            exp_hi = v.e2;
            exp_lo = v.e1;
        end
        check({v.name, ".hi"}, hi, exp_hi);
        check({v.name, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in1 = '0; in2 = '0; control = 4'b0000;

        //  name       in1           in2           ctrl     out1          out2          o     z
        add("and",     32'h55555555, 32'h000000F0, 4'b0000, 32'h00000050, 32'h0,        1'b0, 1'b0);
        add("or",      32'h00000055, 32'h000000A0, 4'b0001, 32'h000000F5, 32'h0,        1'b0, 1'b0);
        add("addu_c",  32'h80000055, 32'h80000001, 4'b0010, 32'h00000056, 32'h0,        1'b1, 1'b0);
        add("addu_z",  32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 32'h0,        1'b1, 1'b1);
        add("subu_b",  32'h00000055, 32'h00000001, 4'b0011, 32'hFFFFFFAC, 32'h0,        1'b1, 1'b0);
        add("subu_eq", 32'hF0FF0055, 32'hF0FF0055, 4'b0011, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("add_ovf", 32'h7FFFFFFF, 32'h00000001, 4'b1010, 32'h80000000, 32'h0,        1'b1, 1'b0);
        add("add_neg", 32'h80000000, 32'h80000000, 4'b1010, 32'h00000000, 32'h0,        1'b1, 1'b1);
        add("sub_ovf", 32'h00000001, 32'h80000000, 4'b1011, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b0);
        add("sub_ok",  32'h00000005, 32'h00000003, 4'b1011, 32'hFFFFFFFE, 32'h0,        1'b0, 1'b0);
        add("slt_1",   32'hFFFFFFFF, 32'h00000001, 4'b0100, 32'h00000001, 32'h0,        1'b0, 1'b0);
        add("slt_0",   32'h00000001, 32'hFFFFFFFF, 4'b0100, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("slt_min", 32'h80000000, 32'h7FFFFFFF, 4'b0100, 32'h00000001, 32'h0,        1'b0, 1'b0);
        add("sltu",    32'hFFFFFFFF, 32'h00000001, 4'b0101, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("nor",     32'hF0F0F0F0, 32'h0F0F0F00, 4'b0111, 32'h0000000F, 32'h0,        1'b0, 1'b0);
        add("mul_s",   32'hFFFFFFFE, 32'h00000003, 4'b1110, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0);
        add("and_hold",32'hFFFFFFFF, 32'h0000FFFF, 4'b0000, 32'h0000FFFF, 32'h0,        1'b0, 1'b0);
        add("mulu",    32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1100, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        add("mulu_z",  32'h00000000, 32'h00000005, 4'b1100, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
        add("divu",    32'h00000007, 32'h00000002, 4'b1101, 32'h00000003, 32'h00000001, 1'b0, 1'b0);
        add("div_s",   32'hFFFFFFF9, 32'h00000002, 4'b1111, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        add("div_s2",  32'h00000007, 32'hFFFFFFFE, 4'b1111, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0);
        add("divu_0",  32'h00000005, 32'h00000000, 4'b1101, 32'hFFFFFFFF, 32'h00000005, 1'b1, 1'b0);
        add("div_0",   32'hFFFFFFF9, 32'h00000000, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0);
        add("div_ovf", 32'h80000000, 32'hFFFFFFFF, 4'b1111, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        add("unused6", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0110, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("unused8", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("unused9", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, 32'h00000000, 32'h0,        1'b0, 1'b1);
        add("mul_end", 32'h00001234, 32'h00010000, 4'b1110, 32'h12340000, 32'h00000000, 1'b0, 1'b0);

        // Reset state.
        #3;
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Control changes to a non-mul/div op before the edge: no capture.
        @(negedge clk);
        in1 = 32'd2; in2 = 32'd3; control = 4'b1100;
        #2;
        control = 4'b0000;
        @(posedge clk);
        #1;
        check("midcycle.hi", hi, exp_hi);
        check("midcycle.lo", lo, exp_lo);

        // Asynchronous reset mid-cycle clears HI/LO at once.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("async_rst.hi", hi, exp_hi);
        check("async_rst.lo", lo, exp_lo);

        // Held in reset: combinational outputs still work, HI/LO stay 0.
        in1 = 32'd3; in2 = 32'd4; control = 4'b1100;
        #1;
        check("rst_comb.out1", out1, 32'd12);
        @(posedge clk);
        #1;
        check("rst_hold.hi", hi, 32'd0);
        check("rst_hold.lo", lo, 32'd0);

        // After release, the next mul/div edge captures.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.hi", hi, 32'd0);
        check("post_rst.lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
